hazard_fwd_unit: RTL and testbench

- Parametrised successor to the stateless ID-stage hazard detector.
- Keeps its own scoreboard of in-flight destinations for DEPTH downstream stages (EXE..WB).
- Produces a load-use/no-forward Stall and registered forwarding selects for the EXE operand muxes.
- Supports a forwarding-disabled mode and a saturating stall performance counter.
- Sits beside the ID/EXE pipeline register.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_match_prio.sv | 39 +++
 rtl/hazard_fwd_unit.sv | 118 +++++++++++
 tb/tb_hazard_fwd_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard/forwarding unit
package hazard_pkg;

    typedef enum logic [1:0] {
        NO_BRANCH = 2'b00,
        BEZ       = 2'b01,
        BNE       = 2'b10,
        JMP       = 2'b11
    } br_type_e;

    // Control flags of one scoreboard entry; the destination index is kept alongside.
    typedef struct packed {
        logic v;
        logic wb;
        logic ld;
    } sb_flags_t;

    localparam int FWD_RF = 0;

endpackage

// File: rtl/hazard_match_prio.sv
// rtl/hazard_match_prio.sv - youngest-producer search over the scoreboard for one source
module hazard_match_prio
    import hazard_pkg::*;
#(
    parameter int REG_W     = 5,
    parameter int DEPTH     = 3,
    parameter int RF_BYPASS = 1,
    parameter int SEL_W     = 2
) (
    input  logic [REG_W-1:0]       i_src,
    input  logic                   i_en,
    input  logic [DEPTH-1:0]       i_v,
    input  logic [DEPTH-1:0]       i_wb,
    input  logic [DEPTH-1:0]       i_ld,
    input  logic [DEPTH*REG_W-1:0] i_dest,
    output logic                   o_hit,
    output logic [SEL_W-1:0]       o_idx,
    output logic                   o_is_load
);

    // With a write-before-read register file the WB entry is already visible to ID.
    localparam int N_CHK = (RF_BYPASS != 0) ? DEPTH - 1 : DEPTH;

    // Scan oldest to youngest so the lowest matching index is the one left standing.
    always_comb begin
        o_hit     = 1'b0;
        o_idx     = '0;
        o_is_load = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if ((k < N_CHK) && i_en && i_v[k] && i_wb[k] && (i_src != '0) &&
                (i_dest[k*REG_W +: REG_W] == i_src)) begin
                o_hit     = 1'b1;
                o_idx     = SEL_W'(k);
                o_is_load = i_ld[k];
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - ID-stage stall detection and registered EXE forwarding selects
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_W     = 5,
    parameter int DEPTH     = 3,
    parameter int LOAD_DIST = 2,
    parameter int RF_BYPASS = 1,
    parameter int SEL_W     = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_Valid,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             Is_Imm,
    input  logic [1:0]       BR_Type,
    input  logic [REG_W-1:0] ID_Dest,
    input  logic             ID_WB_En,
    input  logic             ID_MEM_R_En,
    input  logic             Flush,
    input  logic             Fwd_En,
    output logic             Stall,
    output logic [SEL_W-1:0] Fwd_Sel1,
    output logic [SEL_W-1:0] Fwd_Sel2,
    output logic [CNT_W-1:0] Stall_Cnt
);

    sb_flags_t [DEPTH-1:0]             r_sb;
    logic      [DEPTH-1:0][REG_W-1:0]  r_dest;
    logic      [SEL_W-1:0]             r_sel1;
    logic      [SEL_W-1:0]             r_sel2;
    logic      [CNT_W-1:0]             r_stall_cnt;

    logic [DEPTH-1:0]       w_v;
    logic [DEPTH-1:0]       w_wb;
    logic [DEPTH-1:0]       w_ld;
    logic [DEPTH*REG_W-1:0] w_dest;
    logic                   w_use2;
    logic                   w_hit1, w_hit2;
    logic [SEL_W-1:0]       w_idx1, w_idx2;
    logic                   w_ld1, w_ld2;
    logic                   w_haz1, w_haz2;
    logic                   w_stall;
    logic                   w_issue;
    logic [SEL_W-1:0]       w_sel1_nxt, w_sel2_nxt;

    always_comb begin
        w_v  = '0;
        w_wb = '0;
        w_ld = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_v[k]  = r_sb[k].v;
            w_wb[k] = r_sb[k].wb;
            w_ld[k] = r_sb[k].ld;
        end
    end

    assign w_dest = r_dest;
    assign w_use2 = ~Is_Imm | (BR_Type == BNE);

    hazard_match_prio #(
        .REG_W(REG_W), .DEPTH(DEPTH), .RF_BYPASS(RF_BYPASS), .SEL_W(SEL_W)
    ) u_match1 (
        .i_src(src1), .i_en(1'b1), .i_v(w_v), .i_wb(w_wb), .i_ld(w_ld), .i_dest(w_dest),
        .o_hit(w_hit1), .o_idx(w_idx1), .o_is_load(w_ld1)
    );

    hazard_match_prio #(
        .REG_W(REG_W), .DEPTH(DEPTH), .RF_BYPASS(RF_BYPASS), .SEL_W(SEL_W)
    ) u_match2 (
        .i_src(src2), .i_en(w_use2), .i_v(w_v), .i_wb(w_wb), .i_ld(w_ld), .i_dest(w_dest),
        .o_hit(w_hit2), .o_idx(w_idx2), .o_is_load(w_ld2)
    );

    // A load result is only forwardable once it is at least LOAD_DIST stages ahead.
    function automatic logic is_hazard(input logic hit, input logic [SEL_W-1:0] idx,
                                       input logic ld, input logic fwd);
        return hit & (~fwd | (ld & ((int'(idx) + 1) < LOAD_DIST)));
    endfunction

    assign w_haz1  = is_hazard(w_hit1, w_idx1, w_ld1, Fwd_En);
    assign w_haz2  = is_hazard(w_hit2, w_idx2, w_ld2, Fwd_En);
    assign w_stall = ID_Valid & ~Flush & (w_haz1 | w_haz2);
    assign w_issue = ID_Valid & ~w_stall & ~Flush;

    assign w_sel1_nxt = (w_issue & Fwd_En & w_hit1) ? (w_idx1 + SEL_W'(1)) : SEL_W'(FWD_RF);
    assign w_sel2_nxt = (w_issue & Fwd_En & w_hit2) ? (w_idx2 + SEL_W'(1)) : SEL_W'(FWD_RF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb        <= '0;
            r_dest      <= '0;
            r_sel1      <= SEL_W'(FWD_RF);
            r_sel2      <= SEL_W'(FWD_RF);
            r_stall_cnt <= '0;
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                r_sb[k]   <= r_sb[k-1];
                r_dest[k] <= r_dest[k-1];
            end
            r_sb[0]   <= w_issue ? {1'b1, ID_WB_En, ID_MEM_R_En} : '0;
            r_dest[0] <= w_issue ? ID_Dest : '0;
            r_sel1    <= w_sel1_nxt;
            r_sel2    <= w_sel2_nxt;
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign Stall     = w_stall;
    assign Fwd_Sel1  = r_sel1;
    assign Fwd_Sel2  = r_sel2;
    assign Stall_Cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - self-checking bench for hazard_fwd_unit
module tb_hazard_fwd_unit;

    logic        clk, rst;
    logic        ID_Valid, Is_Imm, ID_WB_En, ID_MEM_R_En, Flush, Fwd_En;
    logic [4:0]  src1, src2, ID_Dest;
    logic [1:0]  BR_Type;
    logic        Stall;
    logic [1:0]  Fwd_Sel1, Fwd_Sel2;
    logic [15:0] Stall_Cnt;

    int checks = 0;
    int failures = 0;
    logic [3:0] exp_q[$];
    logic       st;
    logic [3:0] got, want;

    hazard_fwd_unit dut (
        .clk(clk), .rst(rst), .ID_Valid(ID_Valid), .src1(src1), .src2(src2),
        .Is_Imm(Is_Imm), .BR_Type(BR_Type), .ID_Dest(ID_Dest), .ID_WB_En(ID_WB_En),
        .ID_MEM_R_En(ID_MEM_R_En), .Flush(Flush), .Fwd_En(Fwd_En), .Stall(Stall),
        .Fwd_Sel1(Fwd_Sel1), .Fwd_Sel2(Fwd_Sel2), .Stall_Cnt(Stall_Cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one ID cycle, queue the select pair expected once it reaches EXE, sample Stall,
    // advance a clock and hand back the observed and queued select pairs.
    task automatic step(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                        input logic imm, input logic [1:0] br, input logic [4:0] d,
                        input logic wb, input logic ld, input logic fl, input logic [3:0] e,
                        output logic o_st, output logic [3:0] o_got, output logic [3:0] o_want);
        ID_Valid = v; src1 = s1; src2 = s2; Is_Imm = imm; BR_Type = br;
        ID_Dest = d; ID_WB_En = wb; ID_MEM_R_En = ld; Flush = fl;
        exp_q.push_back(e);
        #2;
        o_st = Stall;
        @(posedge clk); #1;
        o_got  = {Fwd_Sel1, Fwd_Sel2};
        o_want = exp_q.pop_front();
    endtask

    task automatic drain();
        logic ds;
        logic [3:0] dg, dw;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, ds, dg, dw);
    endtask

    task automatic test_reset();
        ID_Valid = 1; src1 = 3; src2 = 3; Is_Imm = 0; BR_Type = 0; ID_Dest = 3;
        ID_WB_En = 1; ID_MEM_R_En = 1; Flush = 0; Fwd_En = 1;
        #1;
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0b want=0", Stall); end
        checks++; if ({Fwd_Sel1, Fwd_Sel2} !== 4'h0) begin failures++; $display("FAIL rst_sel got=%h want=0", {Fwd_Sel1, Fwd_Sel2}); end
        checks++; if (Stall_Cnt !== 16'h0) begin failures++; $display("FAIL rst_cnt got=%h want=0", Stall_Cnt); end
        ID_Valid = 0;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_alu_chain();
        Fwd_En = 1;
        step(1, 1, 2, 0, 0, 3, 1, 0, 0, 4'h0, st, got, want);
        checks++; if (st !== 1'b0) begin failures++; $display("FAIL alu_stall_a got=%0b want=0", st); end
        step(1, 3, 3, 0, 0, 4, 1, 0, 0, 4'h5, st, got, want);
        checks++; if (st !== 1'b0) begin failures++; $display("FAIL alu_stall_b got=%0b want=0", st); end
        checks++; if (got !== want) begin failures++; $display("FAIL alu_sel got=%h want=%h", got, want); end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, st, got, want);
        checks++; if (got !== want) begin failures++; $display("FAIL alu_sel_bubble got=%h want=%h", got, want); end
        drain();
    endtask

    task automatic test_load_use();
        Fwd_En = 1;
        step(1, 1, 0, 1, 0, 5, 1, 1, 0, 4'h0, st, got, want);
        checks++; if (st !== 1'b0) begin failures++; $display("FAIL lu_stall_lw got=%0b want=0", st); end
        step(1, 5, 1, 0, 0, 6, 1, 0, 0, 4'h0, st, got, want);
        checks++; if (st !== 1'b1) begin failures++; $display("FAIL lu_stall_1 got=%0b want=1", st); end
        checks++; if (got !== want) begin failures++; $display("FAIL lu_sel_bubble got=%h want=%h", got, want); end
        step(1, 5, 1, 0, 0, 6, 1, 0, 0, 4'h8, st, got, want);
        checks++; if (st !== 1'b0) begin failures++; $display("FAIL lu_stall_2 got=%0b want=0", st); end
        checks++; if (got !== want) begin failures++; $display("FAIL lu_sel got=%h want=%h", got, want); end
        checks++; if (Stall_Cnt !== 16'd1) begin failures++; $display("FAIL lu_cnt got=%0d want=1", Stall_Cnt); end
        drain();
    endtask

    task automatic test_stall_only();
        Fwd_En = 0;
        step(1, 1, 2, 0, 0, 3, 1, 0, 0, 4'h0, st, got, want);
        for (int i = 0; i < 3; i++) begin
            step(1, 3, 0, 0, 0, 7, 1, 0, 0, 4'h0, st, got, want);
            checks++; if (st !== (i < 2)) begin failures++; $display("FAIL so_stall_%0d got=%0b want=%0b", i, st, i < 2); end
            checks++; if (got !== want) begin failures++; $display("FAIL so_sel_%0d got=%h want=%h", i, got, want); end
        end
        checks++; if (Stall_Cnt !== 16'd3) begin failures++; $display("FAIL so_cnt got=%0d want=3", Stall_Cnt); end
        drain();
    endtask

    task automatic test_imm_r0();
        Fwd_En = 1;
        step(1, 1, 1, 0, 0, 2, 1, 0, 0, 4'h0, st, got, want);
        step(1, 2, 2, 1, 0, 8, 1, 0, 0, 4'h4, st, got, want);
        checks++; if (got !== want) begin failures++; $display("FAIL imm_sel_alu got=%h want=%h", got, want); end
        step(1, 1, 0, 1, 0, 2, 1, 1, 0, 4'h0, st, got, want);
        step(1, 1, 2, 1, 0, 8, 1, 0, 0, 4'h0, st, got, want);
        checks++; if (st !== 1'b0) begin failures++; $display("FAIL imm_stall_ld got=%0b want=0", st); end
        checks++; if (got !== want) begin failures++; $display("FAIL imm_sel_ld got=%h want=%h", got, want); end
        Fwd_En = 0;
        drain();
        step(1, 1, 0, 1, 0, 0, 1, 1, 0, 4'h0, st, got, want);
        step(1, 0, 0, 0, 0, 10, 1, 0, 0, 4'h0, st, got, want);
        checks++; if (st !== 1'b0) begin failures++; $display("FAIL r0_stall got=%0b want=0", st); end
        drain();
    endtask

    task automatic test_branch();
        Fwd_En = 1;
        step(1, 1, 0, 1, 0, 9, 1, 1, 0, 4'h0, st, got, want);
        step(1, 1, 9, 1, 2'b10, 0, 0, 0, 0, 4'h0, st, got, want);
        checks++; if (st !== 1'b1) begin failures++; $display("FAIL bne_stall got=%0b want=1", st); end
        step(1, 1, 9, 1, 2'b10, 0, 0, 0, 0, 4'h2, st, got, want);
        checks++; if (st !== 1'b0) begin failures++; $display("FAIL bne_stall_2 got=%0b want=0", st); end
        checks++; if (got !== want) begin failures++; $display("FAIL bne_sel got=%h want=%h", got, want); end
        drain();
        step(1, 1, 0, 1, 0, 9, 1, 1, 0, 4'h0, st, got, want);
        step(1, 1, 9, 1, 2'b01, 0, 0, 0, 0, 4'h0, st, got, want);
        checks++; if (st !== 1'b0) begin failures++; $display("FAIL bez_stall got=%0b want=0", st); end
        checks++; if (Stall_Cnt !== 16'd4) begin failures++; $display("FAIL br_cnt got=%0d want=4", Stall_Cnt); end
        drain();
    endtask

    task automatic test_flush_reset();
        Fwd_En = 1;
        step(1, 1, 0, 1, 0, 5, 1, 1, 0, 4'h0, st, got, want);
        step(1, 5, 1, 0, 0, 6, 1, 0, 1, 4'h0, st, got, want);
        checks++; if (st !== 1'b0) begin failures++; $display("FAIL flush_stall got=%0b want=0", st); end
        step(1, 6, 1, 0, 0, 7, 1, 0, 0, 4'h0, st, got, want);
        checks++; if (got !== want) begin failures++; $display("FAIL flush_bubble_sel got=%h want=%h", got, want); end
        drain();
        step(1, 1, 2, 0, 0, 3, 1, 0, 0, 4'h0, st, got, want);
        step(1, 3, 0, 1, 0, 5, 1, 1, 0, 4'h4, st, got, want);
        checks++; if (got !== want) begin failures++; $display("FAIL rs_pre_sel got=%h want=%h", got, want); end
        ID_Valid = 1; src1 = 5; src2 = 1; Is_Imm = 0; BR_Type = 0; ID_Dest = 6;
        ID_WB_En = 1; ID_MEM_R_En = 0; Flush = 0;
        #2;
        checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL rs_pre_stall got=%0b want=1", Stall); end
        rst = 1;
        #1;
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL rs_stall got=%0b want=0", Stall); end
        checks++; if ({Fwd_Sel1, Fwd_Sel2} !== 4'h0) begin failures++; $display("FAIL rs_sel got=%h want=0", {Fwd_Sel1, Fwd_Sel2}); end
        checks++; if (Stall_Cnt !== 16'h0) begin failures++; $display("FAIL rs_cnt got=%h want=0", Stall_Cnt); end
        ID_Valid = 0;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_saturation();
        Fwd_En = 0;
        drain();
        force dut.r_stall_cnt = 16'hFFFE;
        @(posedge clk); #1;
        release dut.r_stall_cnt;
        step(1, 1, 2, 0, 0, 3, 1, 0, 0, 4'h0, st, got, want);
        step(1, 3, 0, 0, 0, 7, 1, 0, 0, 4'h0, st, got, want);
        checks++; if (Stall_Cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_inc got=%h want=ffff", Stall_Cnt); end
        step(1, 3, 0, 0, 0, 7, 1, 0, 0, 4'h0, st, got, want);
        checks++; if (st !== 1'b1) begin failures++; $display("FAIL sat_stall got=%0b want=1", st); end
        checks++; if (Stall_Cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h want=ffff", Stall_Cnt); end
        drain();
    endtask

    initial begin
        rst = 1; ID_Valid = 0; src1 = 0; src2 = 0; Is_Imm = 0; BR_Type = 0;
        ID_Dest = 0; ID_WB_En = 0; ID_MEM_R_En = 0; Flush = 0; Fwd_En = 1;
        @(posedge clk); #1;
        test_reset();
        test_alu_chain();
        test_load_use();
        test_stall_only();
        test_imm_r0();
        test_branch();
        test_flush_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
